lcd_timing_controller: RTL
==========================

Name: lcd_timing_controller

Overview:
- Sequences the scanline renderer and arbitrates CPU access to VRAM and OAM.
- Generates dot and line timing, LCD mode (STAT[1:0]), LY, the LY==LYC compare and the VBlank/STAT interrupt pulses.
- Issues one drawline pulse per visible line to the graphics renderer.
- Sits between the LCDC/STAT/LYC register bank and the renderer; its busy flags gate CPU bus decode of VRAM and OAM.

Parameters:
DOTS_PER_LINE, 456, clocks per scanline
OAM_DOTS, 80, mode-2 length in dots
XFER_DOTS, 172, mode-3 length in dots
VISIBLE_LINES, 144, lines rendered (LY 0..143)
TOTAL_LINES, 154, lines per frame including VBlank

Ports:
clk  input  1  system clock, one dot per cycle
rst_n  input  1  asynchronous active-low reset
lcd_enable  input  1  LCDC bit 7
lyc  input  8  LYC register value
stat_ie  input  4  STAT enables: [0] HBlank, [1] VBlank, [2] OAM, [3] LYC
drawline  output  1  one-cycle render-line request
ly  output  8  current line
mode  output  2  0 HBlank, 1 VBlank, 2 OAM search, 3 transfer
lyc_match  output  1  registered (ly == lyc)
vblank_irq  output  1  one-cycle IF bit 0 request
stat_irq  output  1  one-cycle IF bit 1 request
oam_busy  output  1  CPU OAM access blocked
vram_busy  output  1  CPU VRAM access blocked

Behaviour:

Reset:
- rst_n low asynchronously clears dot (9 bit), ly, lyc_match, drawline, vblank_irq, stat_irq and the stat_line history. Mode therefore decodes to 0.
- Reset asserted mid-frame aborts immediately. After release, the controller restarts at dot 0, LY 0.

Counters:
- dot increments each clk while lcd_enable is high.
- At DOTS_PER_LINE-1, dot wraps to 0 and ly increments.
- ly wraps from TOTAL_LINES-1 (153) to 0.

Mode decode (combinational from registered dot/ly):
- ly >= 144: mode 1.
- Otherwise dot < 80: mode 2.
- Otherwise dot < 252: mode 3.
- Otherwise: mode 0.

Busy flags:
- oam_busy = mode 2 or 3.
- vram_busy = mode 3.

drawline:
- Registered; high for exactly one cycle, the cycle after dot==OAM_DOTS-1 with ly<144. This is the first cycle of mode 3.
- Never pulses on lines 144..153.

vblank_irq:
- Registered one-cycle pulse on the cycle ly becomes 144 (dot 0).

lyc_match:
- Registered each cycle as (ly_next == lyc).
- A lyc write mid-line updates lyc_match on the following clock.

stat_irq:
- stat_line = (ie[0]&mode0) | (ie[1]&mode1) | (ie[2]&mode2) | (ie[3]&lyc_match).
- stat_irq pulses for one cycle on a rising edge of stat_line only.
- If stat_line is already high from another source, a new condition produces no second pulse (STAT blocking).
- Enabling a stat_ie bit while its condition is already true produces a pulse if stat_line was low.

LCD off:
- lcd_enable low holds dot=0, ly=0, forces mode to 0 and busy flags to 0.
- drawline, vblank_irq and stat_irq are suppressed while off; lyc_match continues to track (0 == lyc).
- The stat_line history is cleared.
- On re-enable, the first visible cycle is dot 0, LY 0, mode 2. No vblank_irq fires until LY reaches 144.

Simultaneous events:
- At the 143→144 line wrap, the vblank_irq pulse and an ie[1] STAT pulse assert in the same cycle.
- Disabling the LCD on the same edge as a line wrap: disable wins.

Test Plan:
- Release reset with lcd_enable=1, run 456 clks → mode sequence 2 for 80 clks, 3 for 172, 0 for 204; exactly one drawline at dot 80; ly=1 at clk 456.
- Run one full frame (70224 clks) → 144 drawline pulses, one vblank_irq when ly=144, ly wraps 153→0, mode 1 for 4560 clks.
- lyc=0x05, stat_ie=4'b1000 → lyc_match rises and stat_irq pulses once at ly=5 dot 0; no pulse at ly=6.
- stat_ie=4'b0011 across ly 143→144 → single stat_irq at the HBlank entry of line 143; none at VBlank entry because stat_line never fell.
- Drop lcd_enable at ly=50, dot 200 → next clk ly=0, mode=0, busy flags 0, no drawline for 1000 clks; re-enable → mode 2 at ly 0 dot 0.
- Assert rst_n low mid-mode-3 with no clock edge → all outputs 0 immediately; after release, timing restarts from dot 0.

Source files
------------

// File: rtl/lcd_timing_controller.sv
// rtl/lcd_timing_controller.sv - LCD dot/line timing, mode decode, busy flags and interrupt pulses
module lcd_timing_controller #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int XFER_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    output logic       drawline,
    output logic [7:0] ly,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       oam_busy,
    output logic       vram_busy
);

    localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_LAST  = 9'(OAM_DOTS - 1);
    localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] VIS_LINES = 8'(VISIBLE_LINES);
    localparam logic [7:0] LAST_VIS  = 8'(VISIBLE_LINES - 1);
    localparam logic [7:0] LAST_LINE = 8'(TOTAL_LINES - 1);

    logic [8:0] dot;
    logic [8:0] dot_next;
    logic [7:0] ly_next;
    logic [1:0] mode_next;
    logic       end_of_line;
    logic       lyc_match_next;
    logic       stat_line;
    logic       stat_line_next;

    function automatic logic [1:0] decode_mode(input logic [8:0] d, input logic [7:0] l);
        if (l >= VIS_LINES)
            return 2'd1;
        else if (d < OAM_END)
            return 2'd2;
        else if (d < XFER_END)
            return 2'd3;
        else
            return 2'd0;
    endfunction

    assign end_of_line = (dot == LAST_DOT);

    always_comb begin
        dot_next = 9'd0;
        ly_next  = 8'd0;
        if (lcd_enable) begin
            if (end_of_line) begin
                dot_next = 9'd0;
                ly_next  = (ly == LAST_LINE) ? 8'd0 : ly + 8'd1;
            end else begin
                dot_next = dot + 9'd1;
                ly_next  = ly;
            end
        end
    end

    // STAT sources are evaluated on next-state values so the pulse lines up
    // with the cycle the condition becomes visible (e.g. alongside vblank_irq).
    always_comb begin
        mode_next      = decode_mode(dot_next, ly_next);
        lyc_match_next = (ly_next == lyc);
        stat_line_next = (stat_ie[0] && mode_next == 2'd0) ||
                         (stat_ie[1] && mode_next == 2'd1) ||
                         (stat_ie[2] && mode_next == 2'd2) ||
                         (stat_ie[3] && lyc_match_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dot        <= 9'd0;
            ly         <= 8'd0;
            lyc_match  <= 1'b0;
            drawline   <= 1'b0;
            vblank_irq <= 1'b0;
            stat_irq   <= 1'b0;
            stat_line  <= 1'b0;
        end else if (!lcd_enable) begin
            dot        <= 9'd0;
            ly         <= 8'd0;
            lyc_match  <= lyc_match_next;
            drawline   <= 1'b0;
            vblank_irq <= 1'b0;
            stat_irq   <= 1'b0;
            stat_line  <= 1'b0;
        end else begin
            dot        <= dot_next;
            ly         <= ly_next;
            lyc_match  <= lyc_match_next;
            drawline   <= (dot == OAM_LAST) && (ly < VIS_LINES);
            vblank_irq <= end_of_line && (ly == LAST_VIS);
            stat_irq   <= stat_line_next && !stat_line;
            stat_line  <= stat_line_next;
        end
    end

    // Mode is held at 0 while off or in reset so the CPU sees VRAM/OAM free.
    assign mode      = (lcd_enable && rst_n) ? decode_mode(dot, ly) : 2'd0;
    assign oam_busy  = (mode == 2'd2) || (mode == 2'd3);
    assign vram_busy = (mode == 2'd3);

endmodule
